// File: rtl/debug_trace_buf_pkg.sv
// Shared types for the debug trace buffer: FSM state encoding, record layout and width helper.
// Record layout gains a 32-bit timestamp when TRACE_TIMESTAMP_EN is defined.
package debug_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DUMP  = 2'd3
  } trace_state_e;

  localparam int TRACE_XLEN = 32;
  localparam int TSTAMP_W   = 32;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] instr;
    logic [TRACE_XLEN-1:0] alu;
    logic                  mem_we;
    logic [TRACE_XLEN-1:0] mem_addr;
    logic [TRACE_XLEN-1:0] mem_wdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [TSTAMP_W-1:0]   tstamp;
`endif
  } trace_rec_t;

  function automatic int trace_rec_w(input int xlen);
`ifdef TRACE_TIMESTAMP_EN
    return 5 * xlen + 1 + TSTAMP_W;
`else
    return 5 * xlen + 1;
`endif
  endfunction

  localparam int TRACE_REC_W = trace_rec_w(TRACE_XLEN);

endpackage

// File: rtl/debug_trace_buf_if.sv
// Debug tap, control and readout bundle for debug_trace_buf.
// rd_tstamp exists only when TRACE_TIMESTAMP_EN is defined.
interface debug_trace_buf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  logic                     smp_valid;
  logic [XLEN-1:0]          smp_pc;
  logic [XLEN-1:0]          smp_instr;
  logic [XLEN-1:0]          smp_alu;
  logic                     smp_mem_we;
  logic [XLEN-1:0]          smp_mem_addr;
  logic [XLEN-1:0]          smp_mem_wdata;
  logic                     arm;
  logic                     abort;
  logic [XLEN-1:0]          trig_pc;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [XLEN-1:0]          rd_pc;
  logic [XLEN-1:0]          rd_instr;
  logic [XLEN-1:0]          rd_alu;
  logic                     rd_mem_we;
  logic [XLEN-1:0]          rd_mem_addr;
  logic [XLEN-1:0]          rd_mem_wdata;
  logic                     rd_last;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]              rd_tstamp;
`endif
  logic [1:0]               state_o;
  logic [$clog2(DEPTH):0]   entries;

  modport slave (
    input  smp_valid, smp_pc, smp_instr, smp_alu, smp_mem_we, smp_mem_addr, smp_mem_wdata,
    input  arm, abort, trig_pc, rd_ready,
`ifdef TRACE_TIMESTAMP_EN
    output rd_tstamp,
`endif
    output rd_valid, rd_pc, rd_instr, rd_alu, rd_mem_we, rd_mem_addr, rd_mem_wdata, rd_last,
    output state_o, entries
  );

  modport master (
    output smp_valid, smp_pc, smp_instr, smp_alu, smp_mem_we, smp_mem_addr, smp_mem_wdata,
    output arm, abort, trig_pc, rd_ready,
`ifdef TRACE_TIMESTAMP_EN
    input  rd_tstamp,
`endif
    input  rd_valid, rd_pc, rd_instr, rd_alu, rd_mem_we, rd_mem_addr, rd_mem_wdata, rd_last,
    input  state_o, entries
  );

endinterface

// File: rtl/debug_trace_buf_trace_ram.sv
// Simple dual-port trace storage: one write port, one read port with a registered,
// enable-gated output so the read data holds while the consumer stalls.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 161
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/debug_trace_buf.sv
// Per-instruction trace capture buffer: circular capture, PC-match trigger with post-trigger
// window, then oldest-first readout. Timestamp per entry when TRACE_TIMESTAMP_EN is defined.
module debug_trace_buf
  import debug_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic             clk,
  input  logic             rst,
  debug_trace_buf_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = trace_rec_w(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] alu;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]     tstamp;
`endif
  } rec_t;

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] entries_q, entries_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [CW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic          rd_valid_q, rd_valid_d;

  logic          trig_hit;
  logic          smp_store;
  logic          rd_last;
  logic          rd_fire;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  rec_t          wr_rec;
  rec_t          rd_rec;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]   tstamp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + 32'd1;
    end
  end
`endif

  assign trig_hit  = bus.smp_valid && (bus.smp_pc == bus.trig_pc);
  assign smp_store = ((state_q == ARMED) || (state_q == POST)) && bus.smp_valid && !bus.abort;
  // The read register holds one entry, so once every entry is fetched it holds the final one.
  assign rd_last   = rd_valid_q && (fetch_cnt_q == entries_q);
  assign rd_fire   = rd_valid_q && bus.rd_ready;
  assign ram_re    = (state_q == DUMP) && !bus.abort && (fetch_cnt_q != entries_q)
                     && (!rd_valid_q || bus.rd_ready);
  assign ram_raddr = wr_ptr_q - entries_q[AW-1:0] + fetch_cnt_q[AW-1:0];

  always_comb begin
    wr_rec           = '0;
    wr_rec.pc        = bus.smp_pc;
    wr_rec.instr     = bus.smp_instr;
    wr_rec.alu       = bus.smp_alu;
    wr_rec.mem_we    = bus.smp_mem_we;
    wr_rec.mem_addr  = bus.smp_mem_addr;
    wr_rec.mem_wdata = bus.smp_mem_wdata;
`ifdef TRACE_TIMESTAMP_EN
    wr_rec.tstamp    = tstamp_q;
`endif
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (smp_store),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (rd_rec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      entries_q   <= '0;
      post_cnt_q  <= '0;
      fetch_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      entries_q   <= entries_d;
      post_cnt_q  <= post_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.arm) state_d = ARMED;
        ARMED:   if (trig_hit) state_d = (POST_TRIG == 0) ? DUMP : POST;
        POST:    if (bus.smp_valid && (post_cnt_q == AW'(1))) state_d = DUMP;
        DUMP:    if (rd_fire && rd_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    entries_d   = entries_q;
    post_cnt_d  = post_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    rd_valid_d  = rd_valid_q;
    if (bus.abort) begin
      wr_ptr_d    = '0;
      entries_d   = '0;
      post_cnt_d  = '0;
      fetch_cnt_d = '0;
      rd_valid_d  = 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.arm) begin
        wr_ptr_d  = '0;
        entries_d = '0;
      end
      // Once full, the write pointer keeps advancing over the oldest entry.
      if (smp_store) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (entries_q != CW'(DEPTH)) begin
          entries_d = entries_q + 1'b1;
        end
      end
      if ((state_q == ARMED) && trig_hit) begin
        post_cnt_d = AW'(POST_TRIG);
      end else if ((state_q == POST) && bus.smp_valid) begin
        post_cnt_d = post_cnt_q - 1'b1;
      end
      if (state_q == DUMP) begin
        if (ram_re) begin
          fetch_cnt_d = fetch_cnt_q + 1'b1;
          rd_valid_d  = 1'b1;
        end else if (rd_fire) begin
          rd_valid_d  = 1'b0;
        end
        if (rd_fire && rd_last) begin
          entries_d   = '0;
          fetch_cnt_d = '0;
        end
      end
    end
  end

  always_comb begin
    bus.rd_valid     = rd_valid_q;
    bus.rd_last      = rd_last;
    bus.state_o      = state_q;
    bus.entries      = entries_q;
    bus.rd_pc        = '0;
    bus.rd_instr     = '0;
    bus.rd_alu       = '0;
    bus.rd_mem_we    = 1'b0;
    bus.rd_mem_addr  = '0;
    bus.rd_mem_wdata = '0;
`ifdef TRACE_TIMESTAMP_EN
    bus.rd_tstamp    = '0;
`endif
    if (rd_valid_q) begin
      bus.rd_pc        = rd_rec.pc;
      bus.rd_instr     = rd_rec.instr;
      bus.rd_alu       = rd_rec.alu;
      bus.rd_mem_we    = rd_rec.mem_we;
      bus.rd_mem_addr  = rd_rec.mem_addr;
      bus.rd_mem_wdata = rd_rec.mem_wdata;
`ifdef TRACE_TIMESTAMP_EN
      bus.rd_tstamp    = rd_rec.tstamp;
`endif
    end
  end

endmodule

// File: doc/debug_trace_buf.md
Name: debug_trace_buf

Overview:
- Parametrised, per-instruction debug capture buffer. It is the successor to the core's flat live debug ports (pc, instr, alu result, mem write addr/data).
- Records one trace entry per retired instruction into a circular RAM.
- Freezes capture a programmable number of samples after a PC-match trigger, then streams entries out oldest-first over a valid/ready port.
- Sits at top level beside core and memory; driven from the core debug taps.

Parameters:
- XLEN, 32, width of pc/instr/alu/addr/data fields.
- DEPTH, 16, buffer entries; power of two, >= 4.
- POST_TRIG, 8, samples captured after the trigger sample; must satisfy 0 <= POST_TRIG < DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- smp_valid  in  1  one instruction retired this cycle
- smp_pc  in  XLEN  retired PC
- smp_instr  in  XLEN  retired instruction
- smp_alu  in  XLEN  ALU result
- smp_mem_we  in  1  store performed
- smp_mem_addr  in  XLEN  store address
- smp_mem_wdata  in  XLEN  store data
- arm  in  1  pulse: start capture (honoured only in IDLE)
- abort  in  1  pulse: return to IDLE, discard contents
- trig_pc  in  XLEN  trigger PC compare value
- rd_valid  out  1  entry presented
- rd_ready  in  1  consumer accepts entry
- rd_pc, rd_instr, rd_alu, rd_mem_addr, rd_mem_wdata  out  XLEN each  entry fields
- rd_mem_we  out  1  entry field
- rd_last  out  1  presented entry is the final one
- state_o  out  2  0=IDLE 1=ARMED 2=POST 3=DUMP
- entries  out  $clog2(DEPTH)+1  valid entries stored

Behaviour:
- Reset: state IDLE; write pointer, read pointer, entries and post counter all 0. rd_valid=0, rd_last=0, all rd_* fields 0.
- IDLE: no capture. arm=1 -> ARMED next cycle, with wr_ptr=0 and entries=0.
- ARMED: each smp_valid writes the record at wr_ptr, wr_ptr++ mod DEPTH, entries saturates at DEPTH (oldest overwritten).
  - If smp_valid && smp_pc==trig_pc, that sample is stored as normal and the post counter loads POST_TRIG.
  - Next state is DUMP if POST_TRIG==0, else POST.
- POST: each smp_valid stores a sample and decrements the post counter. The cycle that stores the last sample transitions to DUMP. Total stored = min(pre+1+POST_TRIG, DEPTH).
- DUMP: capture halts and smp_* are ignored.
  - Read pointer starts at the oldest entry: (wr_ptr - entries) mod DEPTH.
  - rd_valid=1 the cycle after entering DUMP; registered RAM read gives 1-cycle latency.
  - A transfer occurs on rd_valid && rd_ready. Fields must hold stable while rd_valid && !rd_ready.
  - rd_last=1 with the final entry. After the last transfer: rd_valid=0 next cycle, state IDLE, entries=0.
  - Back-to-back transfers at one per cycle are required (prefetch/skid register).
- abort has priority over arm, trigger and reads in every state: next cycle IDLE, rd_valid=0, entries=0. Same result as rst.
- arm outside IDLE: ignored.
- Trigger and a full buffer in the same cycle: the sample overwrites the oldest entry; the trigger is still honoured.
- trig_pc compare is full-width equality, evaluated only when smp_valid=1.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter (reset 0, wraps at 2^32) is stored with every entry.
  - Extra port rd_tstamp out 32 carries it.
  - Counter runs in all states.
- When undefined: no counter, no rd_tstamp port, no RAM width for it.

Decomposition:
- Package debug_trace_pkg holds:
  - trace_state_e enum (IDLE, ARMED, POST, DUMP).
  - trace_rec_t packed struct (pc, instr, alu, mem_we, mem_addr, mem_wdata, optional tstamp).
  - TRACE_REC_W localparam function.
- One sub-module, trace_ram: simple dual-port, 1 write port / 1 registered read port, parametrised by DEPTH and record width.

Test Plan:
- DEPTH=16, POST_TRIG=8: arm, 20 samples pc=0x100+4k, trig_pc=0x120 (k=8) -> 9 pre+trigger and 8 post, entries=17 capped to 16. Readout begins pc=0x104, ends pc=0x140 with rd_last.
- Trigger on 3rd sample (pc=0x108), POST_TRIG=8 -> entries=11, readout pc 0x100..0x128, rd_last on 11th beat.
- POST_TRIG=0, trigger on 1st sample -> DUMP next cycle, exactly one entry, rd_valid and rd_last asserted together.
- During DUMP hold rd_ready=0 for 5 cycles, then toggle rd_ready every cycle -> fields stable while stalled, no loss or duplication, then IDLE.
- Assert abort in POST, and rst in DUMP -> IDLE next cycle, rd_valid=0, entries=0; a subsequent arm captures cleanly.
- TRACE_TIMESTAMP_EN: samples on cycles 10, 11, 15 after reset -> rd_tstamp 10, 11, 15.
